// File: rtl/freq_gate_ctrl.sv
// Frequency-meter measurement sequencer: gate window, counter clear/latch strobes, range stepping.
// Optional FREQ_AUTO_RANGE_EN: range auto-steps on each LATCH from the sampled count.
module freq_gate_ctrl #(
    parameter int GATE0_CYC  = 500_000,
    parameter int GATE1_CYC  = 5_000_000,
    parameter int GATE2_CYC  = 50_000_000,
    parameter int SYNC_CYC   = 2,
    parameter int RANGE_INIT = 1,
    parameter int CNT_W      = 32,
    parameter logic [CNT_W-1:0] HI_THR = {CNT_W{1'b1}} - 1'b1,
    parameter logic [CNT_W-1:0] LO_THR = 1000
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             range_key_i,
    input  logic [CNT_W-1:0] cnt_val_i,
    input  logic             cnt_ovf_i,
    output logic             gate_o,
    output logic             cnt_clr_o,
    output logic             latch_o,
    output logic [1:0]       range_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic             ovf_flag_o
);

    localparam int MAX01 = (GATE0_CYC > GATE1_CYC) ? GATE0_CYC : GATE1_CYC;
    localparam int MAXG  = (MAX01 > GATE2_CYC) ? MAX01 : GATE2_CYC;
    localparam int CW    = (MAXG > 2) ? $clog2(MAXG) : 1;

    localparam logic [CW-1:0] G0_LD = CW'(GATE0_CYC - 1);
    localparam logic [CW-1:0] G1_LD = CW'(GATE1_CYC - 1);
    localparam logic [CW-1:0] G2_LD = CW'(GATE2_CYC - 1);
    localparam logic [CW-1:0] SY_LD = CW'(SYNC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_HOLD,
        S_LATCH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     range_q, range_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic           gate_q, cnt_clr_q, latch_q, busy_q;
    logic [CW-1:0]  gate_ld;

    always_comb begin
        gate_ld = G1_LD;
        unique case (range_d)
            2'd0:    gate_ld = G0_LD;
            2'd2:    gate_ld = G2_LD;
            default: gate_ld = G1_LD;
        endcase
    end

`ifndef FREQ_AUTO_RANGE_EN
    logic unused_auto;
    assign unused_auto = ^{cnt_val_i, HI_THR, LO_THR};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        range_d = range_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (range_key_i) begin
            range_d = (range_q == 2'd2) ? 2'd0 : range_q + 2'd1;
`ifdef FREQ_AUTO_RANGE_EN
        end else if (state_q == S_LATCH) begin
            if ((cnt_ovf_i || cnt_val_i > HI_THR) && range_q != 2'd0)
                range_d = range_q - 2'd1;
            else if (cnt_val_i < LO_THR && range_q != 2'd2)
                range_d = range_q + 2'd1;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = gate_ld;
                state_d = S_GATE;
            end
            S_GATE: begin
                if (range_key_i) begin
                    state_d = en_i ? S_CLEAR : S_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = SY_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (range_key_i) begin
                    state_d = en_i ? S_CLEAR : S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LATCH: begin
                valid_d = 1'b1;
                ovf_d   = cnt_ovf_i;
                state_d = en_i ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A key press always invalidates the shown result, even one latched now
        if (range_key_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            range_q   <= RANGE_INIT[1:0];
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            gate_q    <= 1'b0;
            cnt_clr_q <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            range_q   <= range_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            gate_q    <= (state_d == S_GATE);
            cnt_clr_q <= (state_d == S_CLEAR);
            latch_q   <= (state_d == S_LATCH);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign gate_o     = gate_q;
    assign cnt_clr_o  = cnt_clr_q;
    assign latch_o    = latch_q;
    assign range_o    = range_q;
    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign ovf_flag_o = ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with short gates (10/20/40 cycles, 2 hold cycles).
// Define FREQ_AUTO_RANGE_EN for both RTL and bench to exercise auto-ranging.
module tb_freq_gate_ctrl;

    logic        clk = 1'b0;
    logic        clr, en, key, ovf;
    logic [31:0] val;
    logic        gate, cnt_clr, latch, busy, valid, ovf_flag;
    logic [1:0]  range;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FREQ_AUTO_RANGE_EN
    localparam int R4 = 0;
`else
    localparam int R4 = 1;
`endif
    localparam int R5 = (R4 == 2) ? 0 : R4 + 1;

    freq_gate_ctrl #(
        .GATE0_CYC (10),
        .GATE1_CYC (20),
        .GATE2_CYC (40),
        .SYNC_CYC  (2),
        .RANGE_INIT(1),
        .CNT_W     (32)
    ) dut (
        .clk_i      (clk),
        .clr_i      (clr),
        .en_i       (en),
        .range_key_i(key),
        .cnt_val_i  (val),
        .cnt_ovf_i  (ovf),
        .gate_o     (gate),
        .cnt_clr_o  (cnt_clr),
        .latch_o    (latch),
        .range_o    (range),
        .busy_o     (busy),
        .valid_o    (valid),
        .ovf_flag_o (ovf_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gate(input string tag);
        int k = 0;
        while (gate !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(gate), 1);
    endtask

    task automatic wait_latch(input string tag);
        int k = 0;
        while (latch !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(latch), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic count_gate(output int n);
        n = 0;
        while (gate === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic press_key();
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
    endtask

    logic tr_gate [50];
    logic tr_clr  [50];
    logic tr_lat  [50];
    logic tr_val  [50];

    initial begin
        int n;
        int s;
        clr = 1'b1;
        en  = 1'b0;
        key = 1'b0;
        ovf = 1'b0;
        val = 32'd5000;
        cyc(2);

        // reset state
        chk("rst_gate", 32'(gate), 0);
        chk("rst_clr", 32'(cnt_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_range", 32'(range), 1);

        // 1: continuous run, period 24
        clr = 1'b0;
        cyc(1);
        en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            tr_gate[k] = gate;
            tr_clr[k]  = cnt_clr;
            tr_lat[k]  = latch;
            tr_val[k]  = valid;
        end
        s = 0;
        for (int k = 1; k <= 20; k++) s += int'(tr_gate[k]);
        chk("t1_clr0", 32'(tr_clr[0]), 1);
        chk("t1_gate0", 32'(tr_gate[0]), 0);
        chk("t1_clr1", 32'(tr_clr[1]), 0);
        chk("t1_gate_len", 32'(s), 20);
        chk("t1_gate21", 32'(tr_gate[21]), 0);
        chk("t1_lat22", 32'(tr_lat[22]), 0);
        chk("t1_lat23", 32'(tr_lat[23]), 1);
        chk("t1_val23", 32'(tr_val[23]), 0);
        chk("t1_val24", 32'(tr_val[24]), 1);
        chk("t1_clr24", 32'(tr_clr[24]), 1);
        chk("t1_gate25", 32'(tr_gate[25]), 1);
        chk("t1_lat47", 32'(tr_lat[47]), 1);
        en = 1'b0;
        wait_idle("t1_idle");

        // 2: range keys in IDLE
        chk("t2_valid_pre", 32'(valid), 1);
        press_key();
        chk("t2_r2", 32'(range), 2);
        chk("t2_valid", 32'(valid), 0);
        press_key();
        chk("t2_r0", 32'(range), 0);
        press_key();
        chk("t2_r1", 32'(range), 1);
        chk("t2_busy", 32'(busy), 0);

        // 3: key at gate cycle 5 aborts, restarts with 40-cycle gate
        en = 1'b1;
        wait_gate("t3_gate");
        cyc(4);
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        chk("t3_gate_drop", 32'(gate), 0);
        chk("t3_clr", 32'(cnt_clr), 1);
        chk("t3_lat", 32'(latch), 0);
        chk("t3_valid", 32'(valid), 0);
        chk("t3_range", 32'(range), 2);
        wait_gate("t3_gate2");
        count_gate(n);
        chk("t3_gate_len", 32'(n), 40);
        en = 1'b0;
        wait_idle("t3_idle");

        // 4: EN drop at gate cycle 3 (range back to 1)
        press_key();
        press_key();
        chk("t4_range", 32'(range), 1);
        en = 1'b1;
        ovf = 1'b1;
        wait_gate("t4_gate");
        cyc(2);
        en = 1'b0;
        count_gate(n);
        chk("t4_gate_len", 32'(2 + n), 20);
        wait_latch("t4_latch");
        cyc(1);
        chk("t4_valid", 32'(valid), 1);
        chk("t4_ovf", 32'(ovf_flag), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_range_after", 32'(range), R4);
        ovf = 1'b0;
        s = 0;
        repeat (10) begin
            @(negedge clk);
            s += int'(cnt_clr);
        end
        chk("t4_no_clr", 32'(s), 0);

        // 5: async reset mid-gate
        press_key();
        chk("t5_range_key", 32'(range), R5);
        en = 1'b1;
        wait_gate("t5_gate");
        cyc(3);
        clr = 1'b1;
        #1;
        chk("t5_gate", 32'(gate), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_ovf", 32'(ovf_flag), 0);
        chk("t5_range", 32'(range), 1);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("t5_restart_clr", 32'(cnt_clr), 1);
        wait_gate("t5_gate2");
        count_gate(n);
        chk("t5_gate_len", 32'(n), 20);

`ifdef FREQ_AUTO_RANGE_EN
        // 6: auto-ranging
        ovf = 1'b1;
        wait_latch("t6_lat1");
        cyc(1);
        chk("t6_down", 32'(range), 0);
        chk("t6_valid1", 32'(valid), 1);
        ovf = 1'b0;
        val = 32'd5;
        wait_latch("t6_lat2");
        cyc(1);
        chk("t6_up", 32'(range), 1);
        chk("t6_valid2", 32'(valid), 1);
        ovf = 1'b1;
        wait_latch("t6_lat3");
        press_key();
        chk("t6_key_wins", 32'(range), 2);
        chk("t6_valid3", 32'(valid), 0);
        ovf = 1'b0;
        val = 32'd5000;
`endif

        en = 1'b0;
        wait_idle("end_idle");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
